// File: rtl/clock_divider_meter.sv
// clock_divider_meter: measures the half-period of clk_in in clk cycles, flags lock and overflow.
// Optional macro CLOCK_DIVIDER_METER_SYNC_EN: adds a two-flop synchronizer ahead of edge detection.
module clock_divider_meter #(
    parameter int COUNT_BIT_WIDTH      = 16,
    parameter int LOCK_COUNT           = 4,
    parameter int LOCK_COUNT_BIT_WIDTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_in,
    output logic [COUNT_BIT_WIDTH-1:0] half_period,
    output logic                       period_valid,
    output logic                       locked,
    output logic                       overflow
);
    localparam logic [0:0] WAIT_EDGE = 1'b0;
    localparam logic [0:0] MEASURE   = 1'b1;
    localparam logic [LOCK_COUNT_BIT_WIDTH-1:0] LOCK_MAX = LOCK_COUNT_BIT_WIDTH'(LOCK_COUNT);

    logic                            synced;
    logic                            s_prev;
    logic                            in_edge;
    logic [0:0]                      state;
    logic [COUNT_BIT_WIDTH-1:0]      count;
    logic [COUNT_BIT_WIDTH-1:0]      prev;
    logic [LOCK_COUNT_BIT_WIDTH-1:0] match_cnt;
    logic [LOCK_COUNT_BIT_WIDTH-1:0] match_nxt;
    logic                            first_cap;

`ifdef CLOCK_DIVIDER_METER_SYNC_EN
    logic s1, s2;
    // two-flop synchronizer for an asynchronous clk_in
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= clk_in;
            s2 <= s1;
        end
    end
    assign synced = s2;
`else
    assign synced = clk_in;
`endif

    // previous input level for both-edge detection
    always_ff @(posedge clk) begin
        s_prev <= reset ? 1'b0 : synced;
    end

    assign in_edge = synced ^ s_prev;

    // match count that a capture of the current count would produce
    always_comb begin
        match_nxt = first_cap ? '0 :
                    (count != prev) ? '0 :
                    (match_cnt == LOCK_MAX) ? match_cnt : match_cnt + LOCK_COUNT_BIT_WIDTH'(1);
    end

    // measurement FSM: count between edges, capture, track lock, saturate into overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_EDGE;
            count        <= '0;
            prev         <= '0;
            match_cnt    <= '0;
            first_cap    <= 1'b0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (state == WAIT_EDGE) begin
                if (in_edge) begin
                    state     <= MEASURE;
                    count     <= COUNT_BIT_WIDTH'(1);
                    first_cap <= 1'b1;
                end
            end else if (in_edge) begin
                half_period  <= count;
                period_valid <= 1'b1;
                count        <= COUNT_BIT_WIDTH'(1);
                prev         <= count;
                first_cap    <= 1'b0;
                match_cnt    <= match_nxt;
                locked       <= (match_nxt == LOCK_MAX);
            end else if (&count) begin
                overflow  <= 1'b1;
                locked    <= 1'b0;
                match_cnt <= '0;
                state     <= WAIT_EDGE;
            end else begin
                count <= count + COUNT_BIT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_clock_divider_meter.sv
// tb_clock_divider_meter: timestamp-based model check of two meter widths plus directed scenarios.
module tb_clock_divider_meter;
    localparam int LOCK = 4;
`ifdef CLOCK_DIVIDER_METER_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clk_in = 1'b0;
    logic [15:0] hp16;
    logic        pv16, lk16, ov16;
    logic [3:0]  hp4;
    logic        pv4, lk4, ov4;
    int          tests = 0;
    int          fails = 0;
    int          period = 0;
    int          gcnt = 0;

    always #5 clk = ~clk;

    clock_divider_meter dut16 (
        .clk(clk), .reset(reset), .clk_in(clk_in),
        .half_period(hp16), .period_valid(pv16), .locked(lk16), .overflow(ov16)
    );

    clock_divider_meter #(.COUNT_BIT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .clk_in(clk_in),
        .half_period(hp4), .period_valid(pv4), .locked(lk4), .overflow(ov4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw input samples since reset, edges found by comparing delayed samples,
    // half-period = distance between edge timestamps, lock = run length of equal captures.
    bit hist[$];
    int m_half[2], m_last[2], m_run[2], m_prevcap[2];
    bit m_pv[2], m_lk[2], m_ov[2], m_meas[2], m_has[2];
    int maxc[2] = '{65535, 15};
    bit seen_reset = 1'b0;

    function automatic bit eff(input int k);
        return (k < 0) ? 1'b0 : hist[k];
    endfunction

    always begin : model
        int t, cap;
        bit e;
        @(posedge clk);
        if (reset) begin
            hist.delete();
            for (int i = 0; i < 2; i++) begin
                m_half[i] = 0; m_last[i] = 0; m_run[i] = 0; m_prevcap[i] = 0;
                m_pv[i] = 0; m_lk[i] = 0; m_ov[i] = 0; m_meas[i] = 0; m_has[i] = 0;
            end
            seen_reset = 1'b1;
        end else begin
            t = hist.size();
            hist.push_back(clk_in);
            e = eff(t - D) != eff(t - 1 - D);
            for (int i = 0; i < 2; i++) begin
                m_pv[i] = 0;
                if (!m_meas[i]) begin
                    if (e) begin
                        m_meas[i] = 1; m_last[i] = t; m_has[i] = 0;
                    end
                end else if (e) begin
                    cap = t - m_last[i];
                    m_half[i] = cap;
                    m_pv[i] = 1;
                    m_last[i] = t;
                    m_run[i] = (m_has[i] && cap == m_prevcap[i]) ? m_run[i] + 1 : 1;
                    m_has[i] = 1;
                    m_prevcap[i] = cap;
                    m_lk[i] = m_run[i] > LOCK;
                end else if (t - m_last[i] >= maxc[i]) begin
                    m_ov[i] = 1; m_lk[i] = 0; m_meas[i] = 0; m_run[i] = 0;
                end
            end
        end
        #1;
        if (seen_reset) begin
            chk("hp16", 32'(hp16), 32'(m_half[0]));
            chk("pv16", 32'(pv16), 32'(m_pv[0]));
            chk("lk16", 32'(lk16), 32'(m_lk[0]));
            chk("ov16", 32'(ov16), 32'(m_ov[0]));
            chk("hp4", 32'(hp4), 32'(m_half[1]));
            chk("pv4", 32'(pv4), 32'(m_pv[1]));
            chk("lk4", 32'(lk4), 32'(m_lk[1]));
            chk("ov4", 32'(ov4), 32'(m_ov[1]));
        end
    end

    // clk_in generator: toggles every `period` cycles, holds when period is 0
    initial forever begin
        @(negedge clk);
        if (period == 0) gcnt = 0;
        else begin
            gcnt = gcnt + 1;
            if (gcnt >= period) begin
                clk_in = ~clk_in;
                gcnt = 0;
            end
        end
    end

    task automatic wait_pv(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pv4 && n < 100);
        if (!pv4) begin
            tests++;
            fails++;
            $display("FAIL %s: period_valid not seen within 100 cycles", name);
        end
    endtask

    initial begin
        int g;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hp16", 32'(hp16), 0);
        chk("rst_pv16", 32'(pv16), 0);
        chk("rst_lk16", 32'(lk16), 0);
        chk("rst_ov16", 32'(ov16), 0);
        chk("rst_hp4", 32'(hp4), 0);
        chk("rst_ov4", 32'(ov4), 0);
        reset = 1'b0;
        period = 5;
        for (int k = 1; k <= 5; k++) begin
            wait_pv("n5");
            chk("n5_hp4", 32'(hp4), 5);
            chk("n5_hp16", 32'(hp16), 5);
            chk("n5_lk4", 32'(lk4), 32'(k == 5));
        end
        period = 7;
        for (int k = 1; k <= 5; k++) begin
            wait_pv("n7");
            chk("n7_hp4", 32'(hp4), 7);
            chk("n7_lk4", 32'(lk4), 32'(k == 5));
            chk("n7_lk16", 32'(lk16), 32'(k == 5));
        end
        period = 1;
        repeat (12) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("n1_pv4", 32'(pv4), 1);
            chk("n1_hp4", 32'(hp4), 1);
            chk("n1_lk4", 32'(lk4), 1);
            chk("n1_pv16", 32'(pv16), 1);
            @(negedge clk);
        end
        period = 0;
        repeat (20) @(negedge clk);
        chk("ovf_ov4", 32'(ov4), 1);
        chk("ovf_lk4", 32'(lk4), 0);
        chk("ovf_hp4", 32'(hp4), 1);
        chk("ovf_ov16", 32'(ov16), 0);
        chk("ovf_lk16", 32'(lk16), 1);
        period = 3;
        wait_pv("n3");
        chk("n3_hp4", 32'(hp4), 3);
        chk("n3_ov4", 32'(ov4), 1);
        wait_pv("n3b");
        chk("n3b_hp4", 32'(hp4), 3);
        period = 6;
        g = 0;
        do begin
            wait_pv("n6");
            g++;
        end while (clk_in != 1'b0 && g < 6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mrst_hp4", 32'(hp4), 0);
        chk("mrst_hp16", 32'(hp16), 0);
        chk("mrst_lk4", 32'(lk4), 0);
        chk("mrst_ov4", 32'(ov4), 0);
        wait_pv("n6r");
        chk("n6r_hp4", 32'(hp4), 6);
        chk("n6r_hp16", 32'(hp16), 6);
        chk("n6r_lk4", 32'(lk4), 0);
        repeat (20) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/clock_divider_meter.md
# clock_divider_meter

Measures the half-period of a slow clock or toggle signal in `clk` cycles and reports when that measurement is stable. It is the receiving end of `clock_divider_one`: fed that block's `clk_div`, it returns the configured `FREQUENCY_DIV_HALF`. It sits beside the dividers and serves as a self-check and frequency monitor for divided or external clocks.

## Interface
- `COUNT_BIT_WIDTH`, 16: width of the half-period counter and of `half_period`.
- `LOCK_COUNT`, 4: number of consecutive matching measurements needed before `locked` asserts.
- `LOCK_COUNT_BIT_WIDTH`, 3: width of the match counter; must hold `LOCK_COUNT`.
- `clk` input 1: system clock. Everything is clocked on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `clk_in` input 1: signal under measurement. It may be asynchronous to `clk`.
- `half_period` output `COUNT_BIT_WIDTH`: last measured number of `clk` cycles between consecutive `clk_in` edges.
- `period_valid` output 1: one-cycle pulse when `half_period` updates.
- `locked` output 1: the last `LOCK_COUNT`+1 measurements were identical.
- `overflow` output 1: sticky flag; the counter saturated without seeing an edge.

## Operation
- **Input path:** `clk_in` passes through the input stage (see Configuration) into `s_prev`.
  - `edge` = synced value XOR `s_prev`.
  - Both rising and falling edges count.
- **States:** WAIT_EDGE and MEASURE.
  - WAIT_EDGE on `edge`: go to MEASURE, set `count` to 1. No measurement is produced.
  - MEASURE on `edge`:
    - `half_period` <= `count`, `period_valid` <= 1, `count` <= 1.
    - Lock update runs (below).
  - MEASURE without `edge`: `count` <= `count`+1.
  - MEASURE, `count` == all-ones and no `edge`:
    - `overflow` <= 1, `locked` <= 0, match counter <= 0.
    - Go to WAIT_EDGE. `half_period` holds its value.
- **Lock update:** runs on every MEASURE capture.
  - First capture after entering MEASURE: store it as `prev`, match counter <= 0.
  - Otherwise, if the new value == `prev`: match counter increments, saturating at `LOCK_COUNT`.
  - Otherwise: match counter <= 0 and `prev` <= the new value.
  - `locked` <= (next match counter == `LOCK_COUNT`). This is registered in the same cycle as `period_valid`.
- **Arithmetic:** unsigned. `count` never wraps; it saturates and raises `overflow`.
- **Clearing `overflow`:** only `reset` clears it. Measurement resumes automatically on the next edge.
- **Reset:** every output is 0, state is WAIT_EDGE, `count`, `prev` and match counter are 0, and the synchronizer flops are 0.
  - Reset mid-measurement discards the partial count.
  - The first `clk_in` high after reset counts as an edge.

## Timing
- Steady input toggling every N `clk` cycles, with N ≥ 1, gives `half_period` = N and one `period_valid` every N cycles.
- Latency, with sync enabled: 3 `clk` edges from a `clk_in` transition sampled to `period_valid` high.
  - One synchronizer flop adds 1 edge, the second adds 1 edge, and the registered output adds 1 edge.
- Latency, with sync disabled: 1 `clk` edge.
- N = 1 is legal: `edge` is true every cycle, `period_valid` stays high continuously and `half_period` = 1.
- `locked` rises together with the (`LOCK_COUNT`+1)-th equal `period_valid`. It falls together with the first mismatching `period_valid`, or on overflow.
- Overflow fires `2^COUNT_BIT_WIDTH - 1` cycles after the last edge.
- If `edge` and saturation occur in the same cycle, the edge wins: capture, no overflow.

## Configuration
- `CLOCK_DIVIDER_METER_SYNC_EN`
  - Defined: `clk_in` passes through a two-flop synchronizer before `s_prev`. Latency is 3.
  - Undefined: `clk_in` is registered once directly into `s_prev` and must be synchronous to `clk`. Latency is 1, and all measured values are unchanged.

## Test plan
- Driven by `clock_divider_one` with `FREQUENCY_DIV_HALF`=5 -> `half_period`=5 and `period_valid` every 5 cycles; `locked`=1 at the 5th pulse.
- `clk_in` toggles every cycle (N=1) -> `period_valid` held high, `half_period`=1, `locked`=1 after 5 cycles of valid.
- Ratio change from 5 to 7 while locked -> first 7 capture clears `locked`; `locked` returns on the 5th consecutive 7.
- `COUNT_BIT_WIDTH`=4, `clk_in` stops -> `overflow`=1 and `locked`=0 after 15 idle cycles; restart toggling at 3 -> `half_period`=3 with `overflow` still 1.
- `reset` asserted for 1 cycle mid-measure with N=6 -> all outputs 0; first capture afterwards comes only after two new edges and equals 6.
- Sync disabled versus enabled with the same stimulus -> identical `half_period` sequence, `period_valid` shifted by 2 cycles.
